// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Multi-cycle access controller that shares one 16-bit, byte-addressed
//   unified memory between the instruction-fetch port (I) and the data
//   port (D). Each word access costs LATENCY cycles: LATENCY-1 idle WAIT
//   cycles followed by one ACCESS cycle with mem_enable high. Single-word
//   reads and writes and aligned block reads (BLOCK_WORDS words, returned
//   in order 0..BLOCK_WORDS-1) are supported.
//
//   Build option: define ARB_RR_EN for round-robin arbitration. When it is
//   undefined, arbitration is fixed priority and D wins every tie.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset
//   i_req/i_blk/i_addr  I-port request, block-read select, byte address
//   d_req/d_wr/d_blk    D-port request, write select, block-read select
//   d_addr/d_wdata      D-port byte address and write data
//   i_gnt/d_gnt         port currently owns the memory
//   i_rvalid/d_rvalid   rdata holds one returned word for that port
//   i_done/d_done       one-cycle completion pulse
//   rdata/widx          registered read data and its word index
//   mem_enable/mem_wr   memory enable and write strobe
//   mem_addr            memory byte address (bit 0 always 0)
//   mem_data_in         memory write data
//   mem_data_out        combinational memory read data
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int LATENCY     = 4,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_req,
  input  logic                           i_blk,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  input  logic                           d_req,
  input  logic                           d_wr,
  input  logic                           d_blk,
  input  logic [ADDR_WIDTH-1:0]          d_addr,
  input  logic [15:0]                    d_wdata,
  output logic                           i_gnt,
  output logic                           d_gnt,
  output logic                           i_rvalid,
  output logic                           d_rvalid,
  output logic                           i_done,
  output logic                           d_done,
  output logic [15:0]                    rdata,
  output logic [$clog2(BLOCK_WORDS)-1:0] widx,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [15:0]                    mem_data_in,
  input  logic [15:0]                    mem_data_out
);

  localparam int WW = $clog2(BLOCK_WORDS);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ~ADDR_WIDTH'(2 * BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t                  state;
  logic                    own_d;
  logic                    lat_wr;
  logic                    lat_blk;
  logic [ADDR_WIDTH-1:0]   base;
  logic [15:0]             wdata_q;
  logic [WW-1:0]           word_cnt;
  logic [LW-1:0]           lat_cnt;

`ifdef ARB_RR_EN
  // 1 when D was the last port served; resets to I so D takes the first tie.
  logic                    last_d;
`endif

  logic                    pick_d;
  logic                    req_wr;
  logic                    req_blk;
  logic [ADDR_WIDTH-1:0]   req_raw;
  logic [ADDR_WIDTH-1:0]   req_base;
  logic [WW-1:0]           word_nxt;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [ADDR_WIDTH-1:0]   next_addr;

  // Winner selection and the attributes latched when leaving IDLE.
  always_comb begin
    pick_d = d_req;
`ifdef ARB_RR_EN
    if (d_req && i_req) pick_d = !last_d;
`endif
    req_wr   = pick_d & d_wr;
    // A D write is always a single word, whatever d_blk says.
    req_blk  = pick_d ? (d_blk & ~d_wr) : i_blk;
    req_raw  = pick_d ? d_addr : i_addr;
    req_base = req_blk ? (req_raw & BLK_MASK) : (req_raw & WORD_MASK);
  end

  always_comb begin
    word_nxt  = word_cnt + WW'(1);
    cur_addr  = base + ADDR_WIDTH'({word_cnt, 1'b0});
    next_addr = base + ADDR_WIDTH'({word_nxt, 1'b0});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      own_d       <= 1'b0;
      lat_wr      <= 1'b0;
      lat_blk     <= 1'b0;
      base        <= '0;
      wdata_q     <= '0;
      word_cnt    <= '0;
      lat_cnt     <= '0;
      i_gnt       <= 1'b0;
      d_gnt       <= 1'b0;
      i_rvalid    <= 1'b0;
      d_rvalid    <= 1'b0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      rdata       <= '0;
      widx        <= '0;
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
`ifdef ARB_RR_EN
      last_d      <= 1'b0;
`endif
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_req || d_req) begin
            own_d    <= pick_d;
            lat_wr   <= req_wr;
            lat_blk  <= req_blk;
            base     <= req_base;
            wdata_q  <= d_wdata;
            word_cnt <= '0;
            lat_cnt  <= '0;
            i_gnt    <= !pick_d;
            d_gnt    <= pick_d;
`ifdef ARB_RR_EN
            last_d   <= pick_d;
`endif
            if (LATENCY == 1) begin
              // No wait cycles: the bus is driven straight from the request.
              state      <= ST_ACCESS;
              mem_enable <= 1'b1;
              mem_wr     <= req_wr;
              mem_addr   <= req_base;
              if (req_wr) mem_data_in <= d_wdata;
            end else begin
              state <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (lat_cnt == LW'(LATENCY - 2)) begin
            lat_cnt    <= '0;
            state      <= ST_ACCESS;
            mem_enable <= 1'b1;
            mem_wr     <= lat_wr;
            mem_addr   <= cur_addr;
            if (lat_wr) mem_data_in <= wdata_q;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end

        ST_ACCESS: begin
          if (!lat_wr) begin
            rdata    <= mem_data_out;
            widx     <= word_cnt;
            i_rvalid <= !own_d;
            d_rvalid <= own_d;
          end
          if (lat_blk && (word_cnt != WW'(BLOCK_WORDS - 1))) begin
            word_cnt <= word_nxt;
            if (LATENCY == 1) begin
              // Back-to-back accesses: enable stays high, address advances.
              mem_addr <= next_addr;
            end else begin
              state      <= ST_WAIT;
              mem_enable <= 1'b0;
              mem_wr     <= 1'b0;
            end
          end else begin
            state      <= ST_DONE;
            mem_enable <= 1'b0;
            mem_wr     <= 1'b0;
            i_done     <= !own_d;
            d_done     <= own_d;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          i_gnt <= 1'b0;
          d_gnt <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int L  = 4;
  localparam int BW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_req, i_blk, d_req, d_wr, d_blk;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, d_gnt, i_rvalid, d_rvalid, i_done, d_done;
  logic [15:0] rdata;
  logic [2:0]  widx;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;

  // Second instance with single-cycle latency.
  logic        q_i_req, q_i_blk, q_d_req, q_d_wr, q_d_blk;
  logic [15:0] q_i_addr, q_d_addr, q_d_wdata;
  logic        q_i_gnt, q_d_gnt, q_i_rvalid, q_d_rvalid, q_i_done, q_d_done;
  logic [15:0] q_rdata;
  logic [2:0]  q_widx;
  logic        q_mem_enable, q_mem_wr;
  logic [15:0] q_mem_addr, q_mem_data_in, q_mem_data_out;

  mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(L), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_blk(i_blk), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_blk(d_blk), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .i_rvalid(i_rvalid), .d_rvalid(d_rvalid),
    .i_done(i_done), .d_done(d_done), .rdata(rdata), .widx(widx),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(1), .BLOCK_WORDS(BW)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(q_i_req), .i_blk(q_i_blk), .i_addr(q_i_addr),
    .d_req(q_d_req), .d_wr(q_d_wr), .d_blk(q_d_blk), .d_addr(q_d_addr), .d_wdata(q_d_wdata),
    .i_gnt(q_i_gnt), .d_gnt(q_d_gnt), .i_rvalid(q_i_rvalid), .d_rvalid(q_d_rvalid),
    .i_done(q_i_done), .d_done(q_d_done), .rdata(q_rdata), .widx(q_widx),
    .mem_enable(q_mem_enable), .mem_wr(q_mem_wr), .mem_addr(q_mem_addr),
    .mem_data_in(q_mem_data_in), .mem_data_out(q_mem_data_out)
  );

  // Memory device: word array, filled on the first clock, written on enable & wr.
  function automatic logic [15:0] init_val(int unsigned a);
    return 16'(a * 32'd40503) ^ 16'h5A5A;
  endfunction

  logic [15:0] mem [32768];
  bit          mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 32768; a++) mem[a] <= init_val(a);
      mem_ready <= 1'b1;
    end else if (mem_enable && mem_wr) begin
      mem[mem_addr[15:1]] <= mem_data_in;
    end
  end
  assign mem_data_out   = mem[mem_addr[15:1]];
  assign q_mem_data_out = mem[q_mem_addr[15:1]];

  // Reference memory contents, updated by the transaction model.
  logic [15:0] ref_mem [32768];
  bit          ref_last;   // 1: D served last

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit pick_d(input bit ir, input bit dr);
    if (!ir) return dr;
    if (!dr) return 1'b0;
`ifdef ARB_RR_EN
    return !ref_last;
`else
    return 1'b1;
`endif
  endfunction

  // Checks one transaction cycle by cycle from the moment its request is
  // sampled in IDLE. Expected timing: word k accessed at j=(k+1)*L, its data
  // valid at j=(k+1)*L+1, done at j=n*L+1, back in IDLE at j=n*L+2.
  task automatic check_txn(input bit own_d, input bit drop_i, input bit drop_d,
                           output logic [15:0] first_addr, output int done_off,
                           output logic [15:0] last_rd, output bit got_d);
    bit wr, blk;
    logic [15:0] addr, base, wd;
    int n, dn;
    wr   = own_d & d_wr;
    blk  = own_d ? (d_blk & !d_wr) : i_blk;
    addr = own_d ? d_addr : i_addr;
    wd   = d_wdata;
    n    = blk ? BW : 1;
    base = blk ? (addr & ~16'(2 * BW - 1)) : (addr & 16'hFFFE);
    dn   = n * L + 1;
    first_addr = '0; done_off = 0; last_rd = '0; got_d = 1'b0;
    for (int j = 1; j <= dn + 1; j++) begin
      bit en, rv;
      int ke, kr;
      logic [15:0] ea, ra;
      @(posedge clk); @(negedge clk);
      ke = j / L - 1;
      kr = (j - 1) / L - 1;
      en = (j % L == 0) && (ke >= 0) && (ke < n);
      rv = !wr && ((j - 1) % L == 0) && (kr >= 0) && (kr < n);
      if (j == 1) got_d = d_gnt;
      chk("i_gnt", i_gnt, !own_d && j <= dn);
      chk("d_gnt", d_gnt, own_d && j <= dn);
      chk("mem_enable", mem_enable, en);
      chk("mem_wr", mem_wr, en && wr);
      if (en) begin
        ea = base + 16'(2 * ke);
        chk("mem_addr", mem_addr, ea);
        if (j == L) first_addr = mem_addr;
        if (wr) begin
          chk("mem_data_in", mem_data_in, wd);
          ref_mem[ea[15:1]] = wd;
        end
      end
      chk("i_rvalid", i_rvalid, rv && !own_d);
      chk("d_rvalid", d_rvalid, rv && own_d);
      if (rv) begin
        ra = base + 16'(2 * kr);
        chk("rdata", rdata, ref_mem[ra[15:1]]);
        chk("widx", widx, kr);
        last_rd = rdata;
      end
      chk("i_done", i_done, !own_d && j == dn);
      chk("d_done", d_done, own_d && j == dn);
      if ((own_d ? d_done : i_done) && done_off == 0) done_off = j;
      if (j == dn) begin
        if (drop_i) i_req = 1'b0;
        if (drop_d) d_req = 1'b0;
      end
    end
    ref_last = own_d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " i_gnt"}, i_gnt, 0);       chk({tag, " d_gnt"}, d_gnt, 0);
    chk({tag, " i_rvalid"}, i_rvalid, 0); chk({tag, " d_rvalid"}, d_rvalid, 0);
    chk({tag, " i_done"}, i_done, 0);     chk({tag, " d_done"}, d_done, 0);
    chk({tag, " rdata"}, rdata, 0);       chk({tag, " widx"}, widx, 0);
    chk({tag, " mem_enable"}, mem_enable, 0); chk({tag, " mem_wr"}, mem_wr, 0);
    chk({tag, " mem_addr"}, mem_addr, 0); chk({tag, " mem_data_in"}, mem_data_in, 0);
  endtask

  typedef struct {
    bit          port_d;
    bit          wr;
    bit          blk;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_first;
    int          exp_done;
    bit          chk_rd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] fa, lr;
    int dof;
    bit gd, own;

    vecs[0] = '{0, 0, 1, 16'h0013, 16'h0000, 16'h0010, 33, 0, 16'h0000};
    vecs[1] = '{1, 1, 0, 16'h0103, 16'hBEEF, 16'h0102, 5,  0, 16'h0000};
    vecs[2] = '{1, 0, 0, 16'h0102, 16'h0000, 16'h0102, 5,  1, 16'hBEEF};
    vecs[3] = '{1, 1, 1, 16'h0031, 16'h1234, 16'h0030, 5,  0, 16'h0000};
    vecs[4] = '{1, 0, 0, 16'h0030, 16'h0000, 16'h0030, 5,  1, 16'h1234};
    vecs[5] = '{1, 0, 1, 16'h003F, 16'h0000, 16'h0030, 33, 0, 16'h0000};
    vecs[6] = '{0, 0, 0, 16'hFFFF, 16'h0000, 16'hFFFE, 5,  0, 16'h0000};
    vecs[7] = '{0, 0, 1, 16'hFFF5, 16'h0000, 16'hFFF0, 33, 0, 16'h0000};

    for (int a = 0; a < 32768; a++) ref_mem[a] = init_val(a);
    ref_last = 1'b0;

    rst = 1'b0;
    i_req = 0; i_blk = 0; i_addr = '0;
    d_req = 0; d_wr = 0; d_blk = 0; d_addr = '0; d_wdata = '0;
    q_i_req = 0; q_i_blk = 0; q_i_addr = '0;
    q_d_req = 0; q_d_wr = 0; q_d_blk = 0; q_d_addr = '0; q_d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset q_i_gnt", q_i_gnt, 0);
    chk("reset q_mem_enable", q_mem_enable, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors.
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].port_d) begin
        d_req = 1; d_wr = vecs[v].wr; d_blk = vecs[v].blk;
        d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
      end else begin
        i_req = 1; i_blk = vecs[v].blk; i_addr = vecs[v].addr;
      end
      check_txn(vecs[v].port_d, !vecs[v].port_d, vecs[v].port_d, fa, dof, lr, gd);
      chk("vec first_addr", fa, vecs[v].exp_first);
      chk("vec done_offset", dof, vecs[v].exp_done);
      if (vecs[v].chk_rd) chk("vec read_back", lr, vecs[v].exp_rd);
    end

    // Both ports held high across three transactions.
    i_req = 1; i_blk = 0; i_addr = 16'h0500;
    d_req = 1; d_wr = 0; d_blk = 0; d_addr = 16'h0600;
    for (int n = 0; n < 3; n++) begin
      bit exp_d;
`ifdef ARB_RR_EN
      exp_d = (n != 1);
`else
      exp_d = 1'b1;
`endif
      own = pick_d(1'b1, 1'b1);
      check_txn(own, n == 2, n == 2, fa, dof, lr, gd);
      chk("contention grant_d", gd, exp_d);
    end

    // Randomized transactions, some with both ports contending.
    for (int it = 0; it < 30; it++) begin
      int mode;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mode = $urandom_range(0, 2);
      i_blk = 1'($urandom_range(0, 1)); i_addr = 16'($urandom);
      d_wr = 1'($urandom_range(0, 1)); d_blk = 1'($urandom_range(0, 1));
      d_addr = 16'($urandom); d_wdata = 16'($urandom);
      if (mode == 0) begin
        i_req = 1; check_txn(1'b0, 1'b1, 1'b0, fa, dof, lr, gd);
      end else if (mode == 1) begin
        d_req = 1; check_txn(1'b1, 1'b0, 1'b1, fa, dof, lr, gd);
      end else begin
        i_req = 1; d_req = 1;
        own = pick_d(1'b1, 1'b1);
        check_txn(own, !own, own, fa, dof, lr, gd);
        check_txn(!own, own, !own, fa, dof, lr, gd);
      end
    end

    // Reset in the middle of an I block read.
    @(negedge clk);
    i_req = 1; i_blk = 1; i_addr = 16'h0200;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); @(negedge clk);
      chk("pre-reset i_gnt", i_gnt, 1);
    end
    #2 rst = 1'b0;
    #1 chk_all_zero("async reset");
    i_req = 0;
    ref_last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("in reset i_done", i_done, 0);
      chk("in reset i_gnt", i_gnt, 0);
    end
    rst = 1'b1;
    d_req = 1; d_wr = 0; d_blk = 0; d_addr = 16'h0040;
    check_txn(1'b1, 1'b0, 1'b1, fa, dof, lr, gd);
    chk("post-reset done_offset", dof, 5);

    // LATENCY=1 block read on the second instance.
    @(negedge clk);
    q_i_req = 1; q_i_blk = 1; q_i_addr = 16'h0020;
    for (int j = 1; j <= 10; j++) begin
      logic [15:0] ra;
      @(posedge clk); @(negedge clk);
      chk("L1 mem_enable", q_mem_enable, j <= 8);
      if (j <= 8) chk("L1 mem_addr", q_mem_addr, 16'h0020 + 16'(2 * (j - 1)));
      chk("L1 i_rvalid", q_i_rvalid, j >= 2 && j <= 9);
      if (j >= 2 && j <= 9) begin
        ra = 16'h0020 + 16'(2 * (j - 2));
        chk("L1 rdata", q_rdata, ref_mem[ra[15:1]]);
        chk("L1 widx", q_widx, j - 2);
      end
      chk("L1 i_done", q_i_done, j == 9);
      chk("L1 i_gnt", q_i_gnt, j <= 9);
      if (j == 9) q_i_req = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
